// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the N-core memory controller and its request sequencer.
// Holds the lane geometry and the sequencer state encoding so that both
// sides agree on core count and per-lane widths.
package gpu_mem_pkg;

  localparam int unsigned N_CORES     = 4;
  localparam int unsigned N_CORES_LOG = 2;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned ADDR_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    WAIT,
    DONE
  } mem_state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating watchdog counter for the memory request sequencer.
//  clk, reset : clock and asynchronous active-high reset
//  clear      : zero the count (has priority over enable)
//  enable     : count this cycle
//  expired    : high during the enabled cycle that is the TIMEOUT-th counted cycle
//               (or any later one), so the owner can leave on that same edge
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // count holds the cycles already spent; the current enabled cycle is count+1.
  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/mem_request_sequencer.sv
// Upstream stage of the N-core memory controller. Captures one per-lane
// request vector from the SIMT control unit, launches a single read or write
// on the shared controller, waits for it to return to ready (with a watchdog),
// then returns per-lane read data and reports done / timeout.
//  clk, reset       : clock, asynchronous active-high reset
//  req_rd, req_wr   : start a read / write (sampled in IDLE only, read wins)
//  core_en          : per-lane participation mask
//  core_addr        : per-lane address, lane i at [i*ADDR_W +: ADDR_W]
//  core_wdata       : per-lane write data, same packing
//  busy             : transaction in flight
//  done             : one-cycle completion pulse
//  err              : sticky timeout flag, cleared on next accepted request
//  core_rdata       : registered per-lane read data
//  core_rvalid      : per-lane read-data valid, pulses with done
//  mc_read/mc_write : one-cycle launch strobes to the controller
//  mc_en/addr/data  : captured request, held ISSUE..DONE, zero in IDLE
//  mc_ready, mc_q   : controller ready and read data
module mem_request_sequencer
  import gpu_mem_pkg::*;
#(
  parameter int unsigned N_CORES = gpu_mem_pkg::N_CORES,
  parameter int unsigned DATA_W  = gpu_mem_pkg::DATA_W,
  parameter int unsigned ADDR_W  = gpu_mem_pkg::ADDR_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_rd,
  input  logic                      req_wr,
  input  logic [N_CORES-1:0]        core_en,
  input  logic [N_CORES*ADDR_W-1:0] core_addr,
  input  logic [N_CORES*DATA_W-1:0] core_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [N_CORES*DATA_W-1:0] core_rdata,
  output logic [N_CORES-1:0]        core_rvalid,
  output logic                      mc_read,
  output logic                      mc_write,
  output logic [N_CORES-1:0]        mc_en,
  output logic [N_CORES*ADDR_W-1:0] mc_addr,
  output logic [N_CORES*DATA_W-1:0] mc_data,
  input  logic                      mc_ready,
  input  logic [N_CORES*DATA_W-1:0] mc_q
);

  mem_state_t state;
  logic       is_read;
  logic       wd_expired;

  mem_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ISSUE),
    .enable ((state == ARM) || (state == WAIT)),
    .expired(wd_expired)
  );

  // mc_en/mc_addr/mc_data double as the capture registers: loaded on accept,
  // cleared when the transaction retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      is_read     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      core_rdata  <= '0;
      core_rvalid <= '0;
      mc_read     <= 1'b0;
      mc_write    <= 1'b0;
      mc_en       <= '0;
      mc_addr     <= '0;
      mc_data     <= '0;
    end else begin
      done        <= 1'b0;
      core_rvalid <= '0;
      mc_read     <= 1'b0;
      mc_write    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_rd || req_wr) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            err      <= 1'b0;
            is_read  <= req_rd;
            mc_en    <= core_en;
            mc_addr  <= core_addr;
            mc_data  <= core_wdata;
            // Strobes are registered, so they are decided here for the ISSUE
            // cycle; an empty mask raises neither.
            mc_read  <= req_rd && (|core_en);
            mc_write <= !req_rd && (|core_en);
          end
        end
        ISSUE: begin
          // An empty mask passes through ISSUE without a strobe, which gives
          // the two-cycle busy window for a no-op request.
          if (mc_en == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= ARM;
          end
        end
        ARM: begin
          // mc_ready is still high from before the launch; ignore it here.
          if (wd_expired) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mc_ready) begin
            state       <= DONE;
            done        <= 1'b1;
            core_rvalid <= mc_en & {N_CORES{is_read}};
            if (is_read) begin
              for (int unsigned i = 0; i < N_CORES; i++) begin
                if (mc_en[i]) begin
                  core_rdata[i*DATA_W +: DATA_W] <= mc_q[i*DATA_W +: DATA_W];
                end
              end
            end
          end else if (wd_expired) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          is_read <= 1'b0;
          mc_en   <= '0;
          mc_addr <= '0;
          mc_data <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_sequencer.sv
module tb_mem_request_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic [3:0]  core_en = '0;
  logic [63:0] core_addr = '0;
  logic [63:0] core_wdata = '0;
  logic        busy, done, err;
  logic [63:0] core_rdata;
  logic [3:0]  core_rvalid;
  logic        mc_read, mc_write;
  logic [3:0]  mc_en;
  logic [63:0] mc_addr, mc_data;
  logic        mc_ready;
  logic [63:0] mc_q = '0;

  always #5 clk = ~clk;

  mem_request_sequencer #(
    .N_CORES(4),
    .DATA_W (16),
    .ADDR_W (16),
    .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .core_en    (core_en),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .core_rdata (core_rdata),
    .core_rvalid(core_rvalid),
    .mc_read    (mc_read),
    .mc_write   (mc_write),
    .mc_en      (mc_en),
    .mc_addr    (mc_addr),
    .mc_data    (mc_data),
    .mc_ready   (mc_ready),
    .mc_q       (mc_q)
  );

  // Controller model: drops ready on the edge that samples a strobe, raises it
  // again m_delay cycles later unless m_hang is set.
  int   m_delay = 1;
  logic m_hang  = 1'b0;
  int   m_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mc_ready <= 1'b1;
      m_cnt    <= 0;
    end else if (mc_read || mc_write) begin
      mc_ready <= 1'b0;
      m_cnt    <= m_delay;
    end else if (!mc_ready && !m_hang) begin
      if (m_cnt <= 1) mc_ready <= 1'b1;
      else            m_cnt    <= m_cnt - 1;
    end
  end

  typedef struct {
    logic [3:0]  rvalid;
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] model_rdata = '0;

  // Per-transaction observations
  int          r_cyc, r_rdp, r_wrp, r_busy;
  logic        r_stable, r_errc1, r_err, r_tail;
  logic [3:0]  r_rv, r_ce;
  logic [63:0] r_rd, r_ca, r_cd;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [3:0] m,
                                        input logic [63:0] q);
    logic [63:0] res;
    res = old;
    for (int i = 0; i < 4; i++) if (m[i]) res[i*16 +: 16] = q[i*16 +: 16];
    return res;
  endfunction

  // Drives one request, then watches cycle by cycle (cycle 1 = first cycle
  // after the accepting edge) until done or the budget runs out.
  task automatic run_txn(input logic rd, input logic wr, input logic [3:0] en,
                         input logic [63:0] addr, input logic [63:0] wdata, input int inject);
    @(negedge clk);
    req_rd = rd; req_wr = wr; core_en = en; core_addr = addr; core_wdata = wdata;
    @(negedge clk);
    req_rd = 1'b0; req_wr = 1'b0; core_en = '0; core_addr = ~addr; core_wdata = ~wdata;
    r_cyc = 0; r_rdp = 0; r_wrp = 0; r_busy = 0; r_stable = 1'b1;
    r_rv = 'x; r_rd = 'x; r_err = 'x; r_errc1 = 'x;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      req_rd = (c == inject);
      r_rdp += int'(mc_read);
      r_wrp += int'(mc_write);
      r_busy += int'(busy);
      if (c == 1) begin
        r_ca = mc_addr; r_cd = mc_data; r_ce = mc_en; r_errc1 = err;
      end else if ({mc_addr, mc_data, mc_en} !== {r_ca, r_cd, r_ce}) begin
        r_stable = 1'b0;
      end
      if (done) begin
        r_cyc = c; r_rv = core_rvalid; r_rd = core_rdata; r_err = err;
        break;
      end
    end
    req_rd = 1'b0;
    @(negedge clk);
    r_tail = busy | done | mc_read | mc_write | (|mc_en) | (|mc_addr) | (|mc_data);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, done, err, core_rdata, core_rvalid, mc_read, mc_write, mc_en, mc_addr, mc_data} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got busy=%b done=%b err=%b rdata=%h mc_en=%h want all 0", busy, done, err, core_rdata, mc_en); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_read();
    mc_q = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}; m_delay = 3; m_hang = 1'b0;
    model_rdata = merge(model_rdata, 4'b1011, mc_q);
    exp_q.push_back('{rvalid: 4'b1011, rdata: model_rdata, err: 1'b0});
    run_txn(1'b1, 1'b0, 4'b1011, 64'h0004_0003_0002_0001, 64'h0, 0);
    e = exp_q.pop_front();
    n_cmp++; if (r_cyc !== 6) begin n_bad++; $display("FAIL read_latency: got %0d want 6", r_cyc); end
    n_cmp++; if (r_rdp !== 1 || r_wrp !== 0) begin n_bad++; $display("FAIL read_strobes: got rd=%0d wr=%0d want rd=1 wr=0", r_rdp, r_wrp); end
    n_cmp++; if (r_rv !== e.rvalid) begin n_bad++; $display("FAIL read_rvalid: got %b want %b", r_rv, e.rvalid); end
    n_cmp++; if (r_rd !== e.rdata) begin n_bad++; $display("FAIL read_rdata: got %h want %h", r_rd, e.rdata); end
    n_cmp++; if (r_rd[47:32] !== 16'h0000) begin n_bad++; $display("FAIL read_lane2_kept: got %h want 0000", r_rd[47:32]); end
    n_cmp++; if (r_tail !== 1'b0) begin n_bad++; $display("FAIL read_tail: got %b want 0", r_tail); end
    // Single-lane read at minimum latency: only lane 2 changes.
    mc_q = {16'h1111, 16'h2222, 16'h3333, 16'h4444}; m_delay = 1;
    model_rdata = merge(model_rdata, 4'b0100, mc_q);
    exp_q.push_back('{rvalid: 4'b0100, rdata: model_rdata, err: 1'b0});
    run_txn(1'b1, 1'b0, 4'b0100, 64'h0, 64'h0, 0);
    e = exp_q.pop_front();
    n_cmp++; if (r_cyc !== 4) begin n_bad++; $display("FAIL read_min_latency: got %0d want 4", r_cyc); end
    n_cmp++; if (r_rv !== e.rvalid || r_rd !== e.rdata) begin n_bad++; $display("FAIL read_lane2: got %b/%h want %b/%h", r_rv, r_rd, e.rvalid, e.rdata); end
  endtask

  task automatic test_write();
    logic [63:0] a, d;
    a = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    d = {16'h5A03, 16'h5A02, 16'h5A01, 16'h5A00};
    m_delay = 2; mc_q = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_q.push_back('{rvalid: 4'b0000, rdata: model_rdata, err: 1'b0});
    run_txn(1'b0, 1'b1, 4'b1111, a, d, 0);
    e = exp_q.pop_front();
    n_cmp++; if (r_wrp !== 1 || r_rdp !== 0) begin n_bad++; $display("FAIL write_strobes: got wr=%0d rd=%0d want wr=1 rd=0", r_wrp, r_rdp); end
    n_cmp++; if (r_ca !== a || r_cd !== d || r_ce !== 4'hF) begin n_bad++; $display("FAIL write_bus: got %h/%h/%h want %h/%h/f", r_ca, r_cd, r_ce, a, d); end
    n_cmp++; if (r_stable !== 1'b1) begin n_bad++; $display("FAIL write_stable: got %b want 1", r_stable); end
    n_cmp++; if (r_cyc !== 5) begin n_bad++; $display("FAIL write_latency: got %0d want 5", r_cyc); end
    n_cmp++; if (r_rv !== e.rvalid || r_err !== e.err || r_rd !== e.rdata) begin n_bad++; $display("FAIL write_result: got rv=%b err=%b rd=%h want rv=%b err=%b rd=%h", r_rv, r_err, r_rd, e.rvalid, e.err, e.rdata); end
    n_cmp++; if (r_tail !== 1'b0) begin n_bad++; $display("FAIL write_tail: got %b want 0", r_tail); end
  endtask

  task automatic test_zero_mask();
    exp_q.push_back('{rvalid: 4'b0000, rdata: model_rdata, err: 1'b0});
    run_txn(1'b1, 1'b0, 4'b0000, 64'h1234, 64'h5678, 0);
    e = exp_q.pop_front();
    n_cmp++; if (r_rdp + r_wrp !== 0) begin n_bad++; $display("FAIL zero_strobes: got %0d want 0", r_rdp + r_wrp); end
    n_cmp++; if (r_cyc !== 2) begin n_bad++; $display("FAIL zero_latency: got %0d want 2", r_cyc); end
    n_cmp++; if (r_busy !== 2 || r_tail !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %0d tail=%b want 2 tail=0", r_busy, r_tail); end
    n_cmp++; if (r_rv !== e.rvalid || r_rd !== e.rdata) begin n_bad++; $display("FAIL zero_result: got %b/%h want %b/%h", r_rv, r_rd, e.rvalid, e.rdata); end
  endtask

  task automatic test_timeout();
    m_hang = 1'b1; m_delay = 1; mc_q = 64'h9999_9999_9999_9999;
    exp_q.push_back('{rvalid: 4'b0000, rdata: model_rdata, err: 1'b1});
    run_txn(1'b1, 1'b0, 4'b1111, 64'h0, 64'h0, 0);
    e = exp_q.pop_front();
    n_cmp++; if (r_cyc !== 10) begin n_bad++; $display("FAIL timeout_latency: got %0d want 10", r_cyc); end
    n_cmp++; if (r_err !== e.err || r_rv !== e.rvalid || r_rd !== e.rdata) begin n_bad++; $display("FAIL timeout_result: got err=%b rv=%b rd=%h want err=%b rv=%b rd=%h", r_err, r_rv, r_rd, e.err, e.rvalid, e.rdata); end
    repeat (2) @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b want 1", err); end
    m_hang = 1'b0;
    exp_q.push_back('{rvalid: 4'b0000, rdata: model_rdata, err: 1'b0});
    run_txn(1'b0, 1'b1, 4'b0001, 64'h7, 64'h8, 0);
    e = exp_q.pop_front();
    n_cmp++; if (r_errc1 !== 1'b0) begin n_bad++; $display("FAIL timeout_err_clear: got %b want 0", r_errc1); end
    n_cmp++; if (r_cyc !== 4 || r_err !== e.err) begin n_bad++; $display("FAIL timeout_recover: got cyc=%0d err=%b want 4/%b", r_cyc, r_err, e.err); end
  endtask

  task automatic test_back_to_back();
    mc_q = {16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D}; m_delay = 3;
    model_rdata = merge(model_rdata, 4'b1111, mc_q);
    exp_q.push_back('{rvalid: 4'b1111, rdata: model_rdata, err: 1'b0});
    run_txn(1'b1, 1'b0, 4'b1111, 64'h0, 64'h0, 3);
    e = exp_q.pop_front();
    n_cmp++; if (r_rdp !== 1 || r_wrp !== 0 || r_cyc !== 6) begin n_bad++; $display("FAIL busy_ignore: got rd=%0d wr=%0d cyc=%0d want 1/0/6", r_rdp, r_wrp, r_cyc); end
    n_cmp++; if (r_rv !== e.rvalid || r_rd !== e.rdata || r_tail !== 1'b0) begin n_bad++; $display("FAIL busy_ignore_result: got %b/%h tail=%b want %b/%h tail=0", r_rv, r_rd, r_tail, e.rvalid, e.rdata); end
    mc_q = {16'hE0E0, 16'hE1E1, 16'hE2E2, 16'hE3E3}; m_delay = 1;
    model_rdata = merge(model_rdata, 4'b0110, mc_q);
    exp_q.push_back('{rvalid: 4'b0110, rdata: model_rdata, err: 1'b0});
    run_txn(1'b1, 1'b1, 4'b0110, 64'h0, 64'hFFFF, 0);
    e = exp_q.pop_front();
    n_cmp++; if (r_rdp !== 1 || r_wrp !== 0) begin n_bad++; $display("FAIL both_req_strobes: got rd=%0d wr=%0d want 1/0", r_rdp, r_wrp); end
    n_cmp++; if (r_rv !== e.rvalid || r_rd !== e.rdata) begin n_bad++; $display("FAIL both_req_result: got %b/%h want %b/%h", r_rv, r_rd, e.rvalid, e.rdata); end
  endtask

  task automatic test_reset_mid();
    m_hang = 1'b1; mc_q = 64'h5555_5555_5555_5555;
    @(negedge clk);
    req_rd = 1'b1; core_en = 4'hF; core_addr = 64'hABCD; core_wdata = 64'h1;
    @(negedge clk);
    req_rd = 1'b0; core_en = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || mc_en !== 4'hF) begin n_bad++; $display("FAIL mid_busy: got busy=%b en=%h want 1/f", busy, mc_en); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({busy, done, err, core_rdata, core_rvalid, mc_read, mc_write, mc_en, mc_addr, mc_data} !== '0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got busy=%b rdata=%h mc_en=%h mc_addr=%h want all 0", busy, core_rdata, mc_en, mc_addr); end
    @(negedge clk);
    reset = 1'b0; m_hang = 1'b0; m_delay = 2;
    model_rdata = merge(64'h0, 4'b0011, mc_q);
    exp_q.push_back('{rvalid: 4'b0011, rdata: model_rdata, err: 1'b0});
    run_txn(1'b1, 1'b0, 4'b0011, 64'h0, 64'h0, 0);
    e = exp_q.pop_front();
    n_cmp++; if (r_cyc !== 5 || r_rv !== e.rvalid || r_rd !== e.rdata) begin n_bad++; $display("FAIL after_reset_txn: got cyc=%0d %b/%h want 5 %b/%h", r_cyc, r_rv, r_rd, e.rvalid, e.rdata); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_zero_mask();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, limit 200000 time units");
    $fatal(1, "global time limit");
  end

endmodule
